frame_column_writer: RTL

// - Writer end of the tile configuration frame interface: turns a 32-bit config word stream into FrameData/FrameStrobe.
// - One instance per fabric column; drives the FrameData rows and FrameStrobe lines that every tile ConfigMem in the column latches.
// - Guarantees latch-safe timing: data is stable one cycle before, during and one cycle after each single-cycle strobe.

---
 rtl/frame_column_writer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/frame_column_writer.sv
// frame_column_writer
// Writer end of the tile configuration frame interface for one fabric column.
// Accepts a stream of config words (header + NumRows data words per frame),
// loads the data into the FrameData rows and fires a single-cycle one-hot
// FrameStrobe pulse with data held stable one cycle before and after it.
//
// Ports
//   CLK            config clock
//   RST            asynchronous, active-high reset
//   s_valid        stream word valid
//   s_data         stream word (header or row data)
//   s_ready        writer accepts a word this cycle
//   FrameData      row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe    one-hot, single-cycle frame latch pulse
//   busy           state is not IDLE
//   err            sticky protocol error (bad magic / frame index out of range)
//   frames_written number of strobes issued, wraps 0xFFFF -> 0
module frame_column_writer #(
   parameter logic [7:0]  COL_ID          = 8'd0,
   parameter int unsigned NumRows         = 4,
   parameter int unsigned FrameBitsPerRow = 32,
   parameter int unsigned MaxFramesPerCol = 20
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 s_valid,
   input  logic [FrameBitsPerRow-1:0]           s_data,
   output logic                                 s_ready,
   output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 busy,
   output logic                                 err,
   output logic [15:0]                          frames_written
);

   localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam int unsigned IdxW = 5;
   localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] SKIP   = 3'd2;
   localparam logic [2:0] SETUP  = 3'd3;
   localparam logic [2:0] STROBE = 3'd4;
   localparam logic [2:0] HOLD   = 3'd5;

   logic [2:0]      state;
   logic [2:0]      nextState;
   logic [RowW-1:0] rowCnt;
   logic [IdxW-1:0] idxQ;
   logic            hdrErr;
   logic            wordAccept;

   // Header field decode
   logic [3:0]      hdrMagic;
   logic [7:0]      hdrCol;
   logic [IdxW-1:0] hdrIdx;
   logic            hdrIdxOk;

   assign hdrMagic   = s_data[31:28];
   assign hdrCol     = s_data[27:20];
   assign hdrIdx     = s_data[19:15];
   assign hdrIdxOk   = 32'(hdrIdx) < MaxFramesPerCol;
   assign wordAccept = s_valid & s_ready;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state and header error decode
   always_comb begin
      nextState = state;
      hdrErr    = 1'b0;
      case (state)
         IDLE: begin
            if (wordAccept) begin
               if (hdrMagic != 4'hA) begin
                  hdrErr = 1'b1;
               end else if (hdrCol == COL_ID) begin
                  if (hdrIdxOk) begin
                     nextState = LOAD;
                  end else begin
                     hdrErr    = 1'b1;
                     nextState = SKIP;
                  end
               end else begin
                  nextState = SKIP;
               end
            end
         end
         LOAD:    if (wordAccept && rowCnt == LastRow) nextState = SETUP;
         SKIP:    if (wordAccept && rowCnt == LastRow) nextState = IDLE;
         SETUP:   nextState = STROBE;
         STROBE:  nextState = HOLD;
         HOLD:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Registered control outputs; ready/busy are decoded from the next state so
   // they line up with the state they describe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s_ready        <= 1'b0;
         busy           <= 1'b0;
         err            <= 1'b0;
         FrameStrobe    <= '0;
         frames_written <= 16'd0;
         rowCnt         <= '0;
         idxQ           <= '0;
      end else begin
         s_ready     <= (nextState == IDLE) || (nextState == LOAD) || (nextState == SKIP);
         busy        <= (nextState != IDLE);
         FrameStrobe <= '0;
         if (nextState == STROBE) begin
            FrameStrobe    <= MaxFramesPerCol'(1) << idxQ;
            frames_written <= frames_written + 16'd1;
         end
         if (hdrErr) err <= 1'b1;
         if (state == IDLE && wordAccept) begin
            rowCnt <= '0;
            idxQ   <= hdrIdx;
         end else if ((state == LOAD || state == SKIP) && wordAccept) begin
            rowCnt <= rowCnt + RowW'(1);
         end
      end
   end

   // Row data registers; only written while loading, so they stay frozen
   // through SETUP/STROBE/HOLD.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         FrameData <= '0;
      end else if (state == LOAD && wordAccept) begin
         for (int r = 0; r < NumRows; r++) begin
            if (rowCnt == RowW'(r))
               FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
         end
      end
   end

endmodule
